// File: rtl/cond_pkg.sv
// Shared types for the condition/flag unit: condition-code encoding,
// flag bit positions and the packed {N,Z,C,V} flag record.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against the stored flags.
module cond_check
   import cond_pkg::*;
(
   input  cond_e  cond,
   input  flags_t flags,
   output logic   cond_ex
);

   always_comb begin
      cond_ex = 1'b1;
      unique case (cond)
         EQ: cond_ex = flags.z;
         NE: cond_ex = ~flags.z;
         CS: cond_ex = flags.c;
         CC: cond_ex = ~flags.c;
         MI: cond_ex = flags.n;
         PL: cond_ex = ~flags.n;
         VS: cond_ex = flags.v;
         VC: cond_ex = ~flags.v;
         HI: cond_ex = flags.c & ~flags.z;
         LS: cond_ex = ~flags.c | flags.z;
         GE: cond_ex = (flags.n == flags.v);
         LT: cond_ex = (flags.n != flags.v);
         GT: cond_ex = ~flags.z & (flags.n == flags.v);
         LE: cond_ex = flags.z | (flags.n != flags.v);
         // NV is treated as always-execute, same as AL
         AL, NV: cond_ex = 1'b1;
         default: cond_ex = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural flag register with condition-gated write strobes and a
// small LIFO of flag snapshots used around exception entry and return.
module cond_flag_unit
   import cond_pkg::*;
#(
   parameter int SAVE_DEPTH = 4
) (
   input  logic       i_CLK,
   input  logic       i_NRESET,
   input  logic [3:0] i_Cond,
   input  logic [3:0] i_ALUFlags,
   input  logic [1:0] i_FlagW,
   input  logic       i_PCS,
   input  logic       i_RegW,
   input  logic       i_MemW,
   input  logic       i_NoWrite,
   input  logic       i_Stall,
   input  logic       i_Push,
   input  logic       i_Pop,
   output logic       o_CondEx,
   output logic       o_PCSrc,
   output logic       o_RegWrite,
   output logic       o_MemWrite,
   output logic [3:0] o_Flags,
   output logic       o_StackFull,
   output logic       o_StackEmpty,
   output logic       o_StackErr
);

   localparam int CW = $clog2(SAVE_DEPTH + 1);
   localparam int IW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

   flags_t          flags_q;
   flags_t          flags_d;
   flags_t          stack_q [SAVE_DEPTH];
   logic [CW-1:0]   count_q;
   logic            err_q;
   logic            cond_ex;

   logic            full;
   logic            empty;
   logic            do_push;
   logic            do_pop;
   logic            conflict;
   logic            push_ok;
   logic            pop_ok;
   logic            err_set;
   logic [IW-1:0]   push_idx;
   logic [IW-1:0]   pop_idx;

   cond_check u_cond_check (
      .cond    (cond_e'(i_Cond)),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // Strobes are gated purely combinationally so they stay valid during a stall
   assign o_CondEx   = cond_ex;
   assign o_PCSrc    = i_PCS & cond_ex;
   assign o_RegWrite = i_RegW & cond_ex & ~i_NoWrite;
   assign o_MemWrite = i_MemW & cond_ex;

   assign full  = (count_q == CW'(SAVE_DEPTH));
   assign empty = (count_q == '0);

   assign do_push  = ~i_Stall & i_Push & ~i_Pop;
   assign do_pop   = ~i_Stall & i_Pop & ~i_Push;
   assign conflict = ~i_Stall & i_Push & i_Pop;
   assign push_ok  = do_push & ~full;
   assign pop_ok   = do_pop & ~empty;
   assign err_set  = (do_push & full) | (do_pop & empty) | conflict;

   assign push_idx = IW'(count_q);
   assign pop_idx  = IW'(count_q - CW'(1));

   always_comb begin
      flags_d = flags_q;
      if (cond_ex & i_FlagW[1]) begin
         flags_d.n = i_ALUFlags[FLAG_N];
         flags_d.z = i_ALUFlags[FLAG_Z];
      end
      if (cond_ex & i_FlagW[0]) begin
         flags_d.c = i_ALUFlags[FLAG_C];
         flags_d.v = i_ALUFlags[FLAG_V];
      end
   end

   // A successful pop takes priority over the ALU flag update
   always_ff @(posedge i_CLK) begin
      if (!i_NRESET) begin
         flags_q <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (pop_ok) begin
            flags_q <= stack_q[pop_idx];
         end else if (!i_Stall) begin
            flags_q <= flags_d;
         end
         if (push_ok) begin
            count_q <= count_q + CW'(1);
         end else if (pop_ok) begin
            count_q <= count_q - CW'(1);
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   // Snapshot contents need no reset; only the count qualifies them
   always_ff @(posedge i_CLK) begin
      if (i_NRESET && push_ok) begin
         stack_q[push_idx] <= flags_q;
      end
   end

   assign o_Flags      = flags_q;
   assign o_StackFull  = full;
   assign o_StackEmpty = empty;
   assign o_StackErr   = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: condition table, directed stack/conflict
// sequences and randomized traffic against a queue-based reference model.
module tb_cond_flag_unit;

   localparam int DEPTH = 4;

   logic       clk;
   logic       nreset;
   logic [3:0] cond;
   logic [3:0] alu;
   logic [1:0] fw;
   logic       pcs, regw, memw, nowrite, stall, push, pop;
   logic       cond_ex, pc_src, reg_write, mem_write;
   logic [3:0] flags;
   logic       st_full, st_empty, st_err;

   int checks = 0;
   int errors = 0;

   cond_flag_unit #(.SAVE_DEPTH(DEPTH)) dut (
      .i_CLK        (clk),
      .i_NRESET     (nreset),
      .i_Cond       (cond),
      .i_ALUFlags   (alu),
      .i_FlagW      (fw),
      .i_PCS        (pcs),
      .i_RegW       (regw),
      .i_MemW       (memw),
      .i_NoWrite    (nowrite),
      .i_Stall      (stall),
      .i_Push       (push),
      .i_Pop        (pop),
      .o_CondEx     (cond_ex),
      .o_PCSrc      (pc_src),
      .o_RegWrite   (reg_write),
      .o_MemWrite   (mem_write),
      .o_Flags      (flags),
      .o_StackFull  (st_full),
      .o_StackEmpty (st_empty),
      .o_StackErr   (st_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] cond;
      logic [3:0] flags;
      logic       exp;
   } vec_t;

   vec_t vecs [26];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clr_in();
      cond = 4'h0; alu = 4'h0; fw = 2'b00;
      pcs = 0; regw = 0; memw = 0; nowrite = 0; stall = 0; push = 0; pop = 0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr_in();
      nreset = 1'b0;
      tick();
      nreset = 1'b1;
   endtask

   task automatic load_flags(input logic [3:0] f);
      clr_in();
      cond = 4'hE; fw = 2'b11; alu = f;
      tick();
      clr_in();
   endtask

   // reference condition evaluation from the architectural rules
   function automatic bit ref_cond(input int c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         0:  return z;
         1:  return !z;
         2:  return cy;
         3:  return !cy;
         4:  return n;
         5:  return !n;
         6:  return v;
         7:  return !v;
         8:  return cy && !z;
         9:  return !cy || z;
         10: return n == v;
         11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   logic [3:0] m_flags;
   logic [3:0] m_stack [$];
   logic       m_err;

   initial begin
      logic [3:0] pushes [4];
      vecs[0]  = '{4'h0, 4'b0100, 1'b1};
      vecs[1]  = '{4'h0, 4'b1011, 1'b0};
      vecs[2]  = '{4'h1, 4'b0000, 1'b1};
      vecs[3]  = '{4'h1, 4'b0100, 1'b0};
      vecs[4]  = '{4'h2, 4'b0010, 1'b1};
      vecs[5]  = '{4'h3, 4'b0010, 1'b0};
      vecs[6]  = '{4'h4, 4'b1000, 1'b1};
      vecs[7]  = '{4'h5, 4'b1000, 1'b0};
      vecs[8]  = '{4'h6, 4'b0001, 1'b1};
      vecs[9]  = '{4'h7, 4'b0000, 1'b1};
      vecs[10] = '{4'h8, 4'b0010, 1'b1};
      vecs[11] = '{4'h8, 4'b0110, 1'b0};
      vecs[12] = '{4'h9, 4'b0000, 1'b1};
      vecs[13] = '{4'h9, 4'b0010, 1'b0};
      vecs[14] = '{4'hA, 4'b1001, 1'b1};
      vecs[15] = '{4'hA, 4'b0001, 1'b0};
      vecs[16] = '{4'hB, 4'b1000, 1'b1};
      vecs[17] = '{4'hB, 4'b0000, 1'b0};
      vecs[18] = '{4'hC, 4'b0000, 1'b1};
      vecs[19] = '{4'hC, 4'b0100, 1'b0};
      vecs[20] = '{4'hC, 4'b1001, 1'b1};
      vecs[21] = '{4'hD, 4'b0100, 1'b1};
      vecs[22] = '{4'hD, 4'b1000, 1'b1};
      vecs[23] = '{4'hD, 4'b0000, 1'b0};
      vecs[24] = '{4'hE, 4'b0000, 1'b1};
      vecs[25] = '{4'hF, 4'b0000, 1'b1};

      nreset = 1'b0;
      clr_in();
      tick();
      tick();
      nreset = 1'b1;

      // reset state
      cond = 4'h0; settle(); check("rst_eq", 8'(cond_ex), 8'h0);
      cond = 4'h1; settle(); check("rst_ne", 8'(cond_ex), 8'h1);
      cond = 4'hE; settle(); check("rst_al", 8'(cond_ex), 8'h1);
      check("rst_flags", 8'(flags), 8'h0);
      check("rst_empty", 8'(st_empty), 8'h1);
      check("rst_full", 8'(st_full), 8'h0);
      check("rst_err", 8'(st_err), 8'h0);

      // condition table
      for (int i = 0; i < 26; i++) begin
         load_flags(vecs[i].flags);
         cond = vecs[i].cond;
         settle();
         check($sformatf("cond_tab%0d", i), 8'(cond_ex), 8'(vecs[i].exp));
      end

      // compare path
      do_reset();
      cond = 4'hE; fw = 2'b11; alu = 4'b0100;
      tick();
      check("cmp_flags", 8'(flags), 8'b0100);
      clr_in(); cond = 4'h0; regw = 1; settle();
      check("cmp_regw", 8'(reg_write), 8'h1);
      nowrite = 1; settle();
      check("cmp_nowrite", 8'(reg_write), 8'h0);

      // suppression
      clr_in(); cond = 4'h1; fw = 2'b11; alu = 4'b1011; pcs = 1; memw = 1; settle();
      check("sup_pcsrc", 8'(pc_src), 8'h0);
      check("sup_memw", 8'(mem_write), 8'h0);
      tick();
      check("sup_flags", 8'(flags), 8'b0100);

      // partial update and signed compares
      do_reset();
      cond = 4'hE; fw = 2'b10; alu = 4'b1111;
      tick();
      check("part_flags", 8'(flags), 8'b1100);
      clr_in();
      cond = 4'hA; settle(); check("part_ge", 8'(cond_ex), 8'h0);
      cond = 4'hC; settle(); check("part_gt", 8'(cond_ex), 8'h0);
      cond = 4'hD; settle(); check("part_le", 8'(cond_ex), 8'h1);

      // stack fill, overflow, drain, underflow
      do_reset();
      pushes[0] = 4'b0001; pushes[1] = 4'b0010; pushes[2] = 4'b0100; pushes[3] = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         load_flags(pushes[i]);
         push = 1;
         tick();
         clr_in();
      end
      check("stk_full", 8'(st_full), 8'h1);
      check("stk_err_pre", 8'(st_err), 8'h0);
      push = 1; tick(); clr_in();
      check("stk_ovf_err", 8'(st_err), 8'h1);
      check("stk_ovf_full", 8'(st_full), 8'h1);
      for (int i = 3; i >= 0; i--) begin
         pop = 1; tick(); clr_in();
         check($sformatf("stk_pop%0d", i), 8'(flags), 8'(pushes[i]));
      end
      check("stk_empty", 8'(st_empty), 8'h1);
      pop = 1; tick(); clr_in();
      check("stk_unf_flags", 8'(flags), 8'b0001);
      check("stk_unf_empty", 8'(st_empty), 8'h1);

      // conflicts
      do_reset();
      load_flags(4'b0011);
      push = 1; tick(); clr_in();
      load_flags(4'b0101);
      pop = 1; cond = 4'hE; fw = 2'b11; alu = 4'b1111;
      tick(); clr_in();
      check("pop_wins", 8'(flags), 8'b0011);
      check("pop_empty", 8'(st_empty), 8'h1);
      stall = 1; push = 1; cond = 4'hE; fw = 2'b11; alu = 4'b1111; pcs = 1; settle();
      check("stall_pcsrc", 8'(pc_src), 8'h1);
      tick(); clr_in();
      check("stall_flags", 8'(flags), 8'b0011);
      check("stall_empty", 8'(st_empty), 8'h1);
      check("stall_err", 8'(st_err), 8'h0);
      push = 1; pop = 1; cond = 4'hE; fw = 2'b11; alu = 4'b1010;
      tick(); clr_in();
      check("pp_err", 8'(st_err), 8'h1);
      check("pp_empty", 8'(st_empty), 8'h1);
      check("pp_flags", 8'(flags), 8'b1010);

      // randomized traffic against the reference model
      do_reset();
      m_flags = 4'h0; m_stack.delete(); m_err = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit cx, popped;
         logic [3:0] nf;
         nreset  = ($urandom_range(0, 49) != 0);
         cond    = 4'($urandom_range(0, 15));
         alu     = 4'($urandom);
         fw      = 2'($urandom);
         pcs     = 1'($urandom);
         regw    = 1'($urandom);
         memw    = 1'($urandom);
         nowrite = 1'($urandom);
         stall   = ($urandom_range(0, 7) == 0);
         push    = ($urandom_range(0, 3) == 0);
         pop     = ($urandom_range(0, 3) == 0);
         settle();
         cx = ref_cond(int'(cond), m_flags);
         check("rnd_condex", 8'(cond_ex), 8'(cx));
         check("rnd_pcsrc", 8'(pc_src), 8'(pcs & cx));
         check("rnd_regw", 8'(reg_write), 8'(regw & cx & !nowrite));
         check("rnd_memw", 8'(mem_write), 8'(memw & cx));
         check("rnd_flags", 8'(flags), 8'(m_flags));
         check("rnd_full", 8'(st_full), 8'(m_stack.size() == DEPTH));
         check("rnd_empty", 8'(st_empty), 8'(m_stack.size() == 0));
         check("rnd_err", 8'(st_err), 8'(m_err));
         if (!nreset) begin
            m_flags = 4'h0; m_stack.delete(); m_err = 1'b0;
         end else if (!stall) begin
            popped = 0;
            nf = m_flags;
            if (push && pop) m_err = 1'b1;
            else if (push) begin
               if (m_stack.size() == DEPTH) m_err = 1'b1;
               else m_stack.push_back(m_flags);
            end else if (pop) begin
               if (m_stack.size() == 0) m_err = 1'b1;
               else begin
                  nf = m_stack.pop_back();
                  popped = 1;
               end
            end
            if (popped) m_flags = nf;
            else begin
               if (cx && fw[1]) m_flags[3:2] = alu[3:2];
               if (cx && fw[0]) m_flags[1:0] = alu[1:0];
            end
         end
         tick();
      end
      nreset = 1'b1;
      clr_in();
      settle();
      check("rnd_end_flags", 8'(flags), 8'(m_flags));
      check("rnd_end_err", 8'(st_err), 8'(m_err));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
